// File: rtl/max_pool_pkg.sv
// rtl/max_pool_pkg.sv - shared constants, widths and state type for the 2x2 max-pooling block
//
// Purpose : default geometry of the pooling stage, the bus widths derived
//           from it, and the row-parity state encoding used by max_pool.
// Contents: COLS, ROWS, W     - default frame geometry and pixel width
//           ROW_W, OUT_W      - input row bus width and pooled row bus width
//           state_t           - EVEN (expecting row 2r) / ODD (expecting row 2r+1)

package max_pool_pkg;

  localparam int COLS  = 28;
  localparam int ROWS  = 28;
  localparam int W     = 16;

  localparam int ROW_W = COLS * W;
  localparam int OUT_W = (COLS / 2) * W;

  typedef enum logic {
    EVEN = 1'b0,
    ODD  = 1'b1
  } state_t;

endpackage

// File: rtl/max_pool_max2.sv
// rtl/max_pool_max2.sv - combinational unsigned two-input maximum
//
// Purpose : y = max(a, b) over unsigned W-bit operands at full width.
// Ports   : a, b - W-bit unsigned operands
//           y    - W-bit larger operand (a when equal)

module max2 #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  assign y = (a >= b) ? a : b;

endmodule

// File: rtl/max_pool.sv
// rtl/max_pool.sv - 2x2 stride-2 max pooling over whole convolution rows
//
// Purpose : accepts one complete input row per in_valid, keeps the horizontal
//           pair maxima of each even row, and on the following odd row emits
//           one pooled row of COLS/2 pixels, registered, one cycle later.
// Ports   : clk       - single clock, rising edge
//           rst       - asynchronous active-low reset
//           in_valid  - in_row carries a full input row this cycle
//           in_row    - COLS pixels, pixel c at [c*W +: W]
//           out_valid - one-cycle pulse per pooled row
//           out_row   - COLS/2 pooled pixels, pixel k at [k*W +: W]; holds otherwise
//           out_last  - qualifies out_valid on the last pooled row of a frame
//           row_idx   - index of the next input row expected

module max_pool #(
  parameter int COLS = max_pool_pkg::COLS,
  parameter int ROWS = max_pool_pkg::ROWS,
  parameter int W    = max_pool_pkg::W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [COLS*W-1:0]           in_row,
  output logic                        out_valid,
  output logic [(COLS/2)*W-1:0]       out_row,
  output logic                        out_last,
  output logic [$clog2(ROWS)-1:0]     row_idx
);

  import max_pool_pkg::*;

  localparam int HALF = COLS / 2;
  localparam int IW   = $clog2(ROWS);

  state_t              state;
  state_t              state_nxt;
  logic [IW-1:0]       row_idx_nxt;
  logic                load_buf;
  logic                emit;
  logic                last_nxt;

  logic [HALF*W-1:0]   row_buf;
  logic [HALF*W-1:0]   hmax;
  logic [HALF*W-1:0]   vmax;

  // Horizontal pair max of the incoming row feeds both the buffer (even
  // rows) and the vertical compare against the buffer (odd rows), so one
  // comparator per pair and one per column-pair covers both phases.
  for (genvar k = 0; k < HALF; k++) begin : g_pool
    max2 #(.W(W)) u_hmax (
      .a (in_row[(2*k)*W   +: W]),
      .b (in_row[(2*k+1)*W +: W]),
      .y (hmax[k*W +: W])
    );

    max2 #(.W(W)) u_vmax (
      .a (hmax[k*W +: W]),
      .b (row_buf[k*W +: W]),
      .y (vmax[k*W +: W])
    );
  end

  always_comb begin
    state_nxt   = state;
    row_idx_nxt = row_idx;
    load_buf    = 1'b0;
    emit        = 1'b0;
    last_nxt    = 1'b0;

    if (in_valid) begin
      if (row_idx == IW'(ROWS - 1)) begin
        row_idx_nxt = '0;
      end else begin
        row_idx_nxt = row_idx + IW'(1);
      end

      case (state)
        EVEN: begin
          load_buf  = 1'b1;
          state_nxt = ODD;
        end
        ODD: begin
          emit      = 1'b1;
          last_nxt  = (row_idx == IW'(ROWS - 1));
          state_nxt = EVEN;
        end
        default: begin
          state_nxt = EVEN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= EVEN;
      row_idx <= '0;
    end else begin
      state   <= state_nxt;
      row_idx <= row_idx_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_buf <= '0;
    end else if (load_buf) begin
      row_buf <= hmax;
    end
  end

  // out_valid/out_last are recomputed every cycle so they can only be high
  // on the cycle right after an odd-row acceptance; out_row only loads then.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_row   <= '0;
    end else begin
      out_valid <= emit;
      out_last  <= last_nxt;
      if (emit) begin
        out_row <= vmax;
      end
    end
  end

endmodule

// File: tb/tb_max_pool.sv
// tb/tb_max_pool.sv - directed self-checking bench for max_pool

module tb_max_pool;

  localparam int C  = 28;
  localparam int R  = 28;
  localparam int PW = 16;
  localparam int H  = C / 2;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic [C*PW-1:0]   in_row;
  logic              out_valid;
  logic [H*PW-1:0]   out_row;
  logic              out_last;
  logic [4:0]        row_idx;

  int n_chk;
  int n_pass;

  max_pool #(.COLS(C), .ROWS(R), .W(PW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_row    (in_row),
    .out_valid (out_valid),
    .out_row   (out_row),
    .out_last  (out_last),
    .row_idx   (row_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drive on the falling edge, let the rising edge act, sample 1ns later.
  task automatic step(input logic v, input logic [C*PW-1:0] r);
    @(negedge clk);
    in_valid = v;
    in_row   = r;
    @(posedge clk);
    #1;
  endtask

  // Release lands 1ns after a rising edge so the very next edge can accept.
  task automatic do_reset;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    in_row   = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  function automatic logic [C*PW-1:0] fill_in(input logic [PW-1:0] v);
    logic [C*PW-1:0] r;
    for (int c = 0; c < C; c++) r[c*PW +: PW] = v;
    return r;
  endfunction

  function automatic logic [H*PW-1:0] fill_out(input logic [PW-1:0] v);
    logic [H*PW-1:0] r;
    for (int k = 0; k < H; k++) r[k*PW +: PW] = v;
    return r;
  endfunction

  logic [C*PW-1:0] ra, rb;
  logic [H*PW-1:0] ex;
  int              pulses;
  int              v;

  initial begin
    n_chk    = 0;
    n_pass   = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_row   = '0;

    // Reset state, forced asynchronously before any clock edge.
    #2 rst = 1'b0;
    #1;
    chk("reset_out_valid", 256'(out_valid), 256'(0));
    chk("reset_out_last",  256'(out_last),  256'(0));
    chk("reset_out_row",   256'(out_row),   256'(0));
    chk("reset_row_idx",   256'(row_idx),   256'(0));
    @(posedge clk);
    #1 rst = 1'b1;

    // Rows 0 (c) and 1 (100+c) back-to-back: out[k] = 101+2k.
    for (int c = 0; c < C; c++) begin
      ra[c*PW +: PW] = PW'(c);
      rb[c*PW +: PW] = PW'(100 + c);
    end
    for (int k = 0; k < H; k++) ex[k*PW +: PW] = PW'(101 + 2*k);
    step(1'b1, ra);
    chk("t1_even_no_valid", 256'(out_valid), 256'(0));
    chk("t1_row_idx_1",     256'(row_idx),   256'(1));
    step(1'b1, rb);
    chk("t1_out_valid",     256'(out_valid), 256'(1));
    chk("t1_out_last",      256'(out_last),  256'(0));
    chk("t1_out_row",       256'(out_row),   256'(ex));
    chk("t1_row_idx_2",     256'(row_idx),   256'(2));
    step(1'b0, '0);
    chk("t1_pulse_one_cycle", 256'(out_valid), 256'(0));
    chk("t1_out_row_holds",   256'(out_row),   256'(ex));

    // Even row of 7FFF, five idle cycles, odd row of 1s.
    do_reset();
    step(1'b1, fill_in(16'h7FFF));
    for (int i = 0; i < 5; i++) begin
      step(1'b0, '0);
      chk("t2_gap_no_valid", 256'(out_valid), 256'(0));
    end
    chk("t2_gap_row_idx", 256'(row_idx), 256'(1));
    step(1'b1, fill_in(16'h0001));
    chk("t2_out_valid", 256'(out_valid), 256'(1));
    chk("t2_out_row",   256'(out_row),   256'(fill_out(16'h7FFF)));

    // Mid-frame async reset after an even row, then rows A=3, B=9.
    step(1'b1, fill_in(16'h0005));
    #2 rst = 1'b0;
    #1;
    chk("t3_async_row_idx", 256'(row_idx),   256'(0));
    chk("t3_async_out_row", 256'(out_row),   256'(0));
    chk("t3_async_valid",   256'(out_valid), 256'(0));
    @(posedge clk);
    #1;
    chk("t3_in_reset_valid", 256'(out_valid), 256'(0));
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    step(1'b1, fill_in(16'h0003));
    chk("t3_a_no_valid", 256'(out_valid), 256'(0));
    step(1'b1, fill_in(16'h0009));
    chk("t3_b_valid",    256'(out_valid), 256'(1));
    chk("t3_b_out_row",  256'(out_row),   256'(fill_out(16'h0009)));
    chk("t3_b_out_last", 256'(out_last),  256'(0));

    // Tie and winner-position cases, one per pooled column (k mod 5).
    do_reset();
    for (int k = 0; k < H; k++) begin
      case (k % 5)
        0: begin ra[2*k*PW +: 2*PW] = {16'h0000, 16'h0000}; rb[2*k*PW +: 2*PW] = {16'h0000, 16'h0000}; ex[k*PW +: PW] = 16'h0000; end
        1: begin ra[2*k*PW +: 2*PW] = {16'h1234, 16'h1234}; rb[2*k*PW +: 2*PW] = {16'h1234, 16'h1234}; ex[k*PW +: PW] = 16'h1234; end
        2: begin ra[2*k*PW +: 2*PW] = {16'h0002, 16'h0001}; rb[2*k*PW +: 2*PW] = {16'hFFFF, 16'h0003}; ex[k*PW +: PW] = 16'hFFFF; end
        3: begin ra[2*k*PW +: 2*PW] = {16'h0005, 16'h8000}; rb[2*k*PW +: 2*PW] = {16'h0000, 16'h7FFF}; ex[k*PW +: PW] = 16'h8000; end
        default: begin ra[2*k*PW +: 2*PW] = {16'h0000, 16'h0000}; rb[2*k*PW +: 2*PW] = {16'h0000, 16'hABCD}; ex[k*PW +: PW] = 16'hABCD; end
      endcase
    end
    step(1'b1, ra);
    step(1'b1, rb);
    chk("t4_out_valid", 256'(out_valid), 256'(1));
    chk("t4_out_row",   256'(out_row),   256'(ex));

    // Two full frames back-to-back: frame 0 ascending, frame 1 descending.
    do_reset();
    pulses = 0;
    for (int f = 0; f < 2; f++) begin
      for (int r = 0; r < R; r++) begin
        for (int c = 0; c < C; c++) begin
          v = r*C + c;
          ra[c*PW +: PW] = (f == 0) ? PW'(v & 32'h7FFF) : PW'(1000 - v);
        end
        step(1'b1, ra);
        if (out_valid === 1'b1) pulses++;
        if (r % 2 == 1) begin
          for (int k = 0; k < H; k++)
            ex[k*PW +: PW] = (f == 0) ? PW'(r*C + 2*k + 1) : PW'(1000 - ((r-1)*C + 2*k));
          chk("t5_odd_valid", 256'(out_valid), 256'(1));
          chk("t5_out_row",   256'(out_row),   256'(ex));
          chk("t5_out_last",  256'(out_last),  256'(r == R-1));
        end else begin
          chk("t5_even_valid", 256'(out_valid), 256'(0));
          chk("t5_even_last",  256'(out_last),  256'(0));
        end
      end
      chk("t5_frame_row_idx", 256'(row_idx), 256'(0));
      chk("t5_pulse_count",   256'(pulses),  256'(14 * (f + 1)));
    end
    step(1'b0, '0);
    chk("t5_tail_no_valid", 256'(out_valid), 256'(0));
    chk("t5_tail_no_last",  256'(out_last),  256'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
